nor_tree_pipe: RTL and testbench
================================

Name: nor_tree_pipe

Overview:
- Parametrised, pipelined successor to the fixed 3-input NOR cell.
- Reduces an N-bit input vector to one bit. The result is NOR by default, or OR when the polarity bit is set.
- Uses a tree of RADIX-input OR groups, with one register level per tree level, plus a valid pipeline with stall.
- Includes a saturating counter of asserted results. Used in the mcu9t3v3 cell-characterisation and zero-detect datapaths.

Parameters:
- N, 9, number of input bits; legal range 2..64.
- RADIX, 3, fan-in of each tree node; legal range 2..4.
- CW, 8, width of the saturating result counter; legal range 1..16.
- LEVELS (derived, not overridable), ceil(log_RADIX(N)), number of register stages; always at least 1.

Ports:
- ck  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  pipeline advance enable; when 0 every register holds.
- vi  input  1  input sample valid.
- i  input  N  input vector.
- pol  input  1  0 = NOR result, 1 = OR result; sampled together with i.
- clr  input  1  synchronous counter clear.
- vo  output  1  result valid.
- nq  output  1  registered result.
- cnt  output  CW  saturating count of valid results equal to 1.

Behaviour:
- Reset: asynchronous on nrst=0. All tree data registers, valid bits, pol bits, nq, vo and cnt go to 0. Release is synchronous to ck.
- Level k (k = 1..LEVELS):
  - Groups the previous level's bits in index order, RADIX per group.
  - Zero-pads the final partial group.
  - ORs each group and registers the result.
  - Width of level k is ceil(W(k-1)/RADIX), with W0 = N.
- Last level: registers the single bit nq = (OR of the whole tree) XOR ~pol.
  - pol=0 gives nq = ~|i.
  - pol=1 gives nq = |i.
- pol and vi travel alongside the data, one register per level, so each result uses the pol captured with its own sample.
- Latency: exactly LEVELS enabled cycles from vi/i/pol to vo/nq. For N=9, RADIX=3 this is 2. For N=2, RADIX=2 this is 1.
- en=0: every stage register, valid bit, nq, vo and cnt hold their values. In-flight samples are neither lost nor duplicated.
- Data registers update on every enabled cycle, whatever the valid bit. Their contents are don't-care when the valid bit is 0.
- nq updates only on an enabled cycle in which the last stage's incoming valid bit is 1; otherwise it holds its last valid result.
- vo equals the registered valid of the last stage and is high for one enabled cycle per sample. Back-to-back samples give back-to-back vo.
- cnt, evaluated on each rising edge:
  - If clr=1, cnt becomes 0. This applies regardless of en and takes priority over a simultaneous increment.
  - Else, if en=1, the incoming last-stage valid is 1, the result being registered is 1, and cnt < 2^CW-1, then cnt increments by 1.
  - At 2^CW-1 the count saturates and holds; it never wraps.
- Reset mid-operation discards all in-flight samples. After release, vo stays 0 until new samples have propagated LEVELS enabled cycles.
- Parameter violations (N<2, RADIX outside 2..4, CW outside 1..16) are caught by an elaboration-time check that halts elaboration.

Decomposition:
- Package nor_tree_pkg holds:
  - function clog_radix(n, r), the integer ceil-log in base r with a minimum of 1;
  - function level_width(n, r, k);
  - a constant for the maximum supported N.
- Sub-module nor_tree_level(WIN, RADIX) implements one level: OR groups with zero pad, plus the data/valid/pol register with en. It is instantiated LEVELS-1 times through generate.
- The final level, the nq register and the counter live in the top module.

Test Plan:
- Reset and idle: hold nrst=0 with i=9'h1FF, vi=1. Release, then drive vi=0 for 5 cycles -> nq=0, vo=0 and cnt=0 throughout.
- Basic NOR, N=9, RADIX=3, pol=0, en=1:
  - i=9'h000 with vi=1 -> two cycles later vo=1, nq=1, and cnt becomes 1.
  - i=9'h100 -> nq=0 and cnt stays 1.
- Padding and OR mode, N=7, RADIX=3, pol=1: i=7'h40 (the bit in the padded group) -> vo=1, nq=1 after 2 cycles.
- Stall: issue samples A=0 and B=9'h001 back-to-back, then drop en for 3 cycles mid-flight. Expect:
  - vo and nq frozen while en=0;
  - after en returns, A gives nq=1 and B gives nq=0 in consecutive cycles;
  - no duplicated or lost vo pulses.
- Counter saturation and clear, CW=2: stream 5 valid zero vectors -> cnt reads 1, 2, 3, 3, 3. Asserting clr on the same cycle as an increment -> cnt=0.
- Reset mid-flight: with 2 samples in flight, pulse nrst low asynchronously, between clock edges. Expect vo, nq and cnt to drop to 0 immediately, and no vo to appear for the discarded samples.

Source files
------------

// File: rtl/nor_tree_pkg.sv
// Shared sizing helpers for the pipelined OR/NOR reduction tree.
package nor_tree_pkg;

   localparam int unsigned MaxN = 64;

   // Ceil-log in base r, never below 1 so a 2-input tree still gets one register stage.
   function automatic int unsigned clog_radix(int unsigned n, int unsigned r);
      int unsigned w = n;
      int unsigned l = 0;
      for (int j = 0; j < 64; j++) begin
         if (w > 1) begin
            w = (w + r - 1) / r;
            l++;
         end
      end
      return (l == 0) ? 1 : l;
   endfunction

   function automatic int unsigned level_width(int unsigned n, int unsigned r, int unsigned k);
      int unsigned w = n;
      for (int unsigned j = 0; j < k; j++) begin
         w = (w + r - 1) / r;
      end
      return w;
   endfunction

endpackage

// File: rtl/nor_tree_level.sv
// One tree level: zero-padded RADIX-wide OR groups, registered with valid and polarity.
module nor_tree_level #(
   parameter int unsigned  WIN   = 9,
   parameter int unsigned  RADIX = 3,
   localparam int unsigned WOUT  = (WIN + RADIX - 1) / RADIX
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            en_i,
   input  logic            v_i,
   input  logic            pol_i,
   input  logic [WIN-1:0]  d_i,
   output logic            v_o,
   output logic            pol_o,
   output logic [WOUT-1:0] d_o
);

   localparam int unsigned PW = WOUT * RADIX;

   logic [PW-1:0]   pad;
   logic [WOUT-1:0] d_d, d_q;
   logic            v_q, pol_q;

   assign pad = PW'(d_i);

   always_comb begin
      d_d = '0;
      for (int g = 0; g < WOUT; g++) begin
         d_d[g] = |pad[g*RADIX +: RADIX];
      end
   end

   // Data advances on every enabled cycle; its value only matters when v_q is set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_q   <= '0;
         v_q   <= 1'b0;
         pol_q <= 1'b0;
      end else if (en_i) begin
         d_q   <= d_d;
         v_q   <= v_i;
         pol_q <= pol_i;
      end
   end

   assign d_o   = d_q;
   assign v_o   = v_q;
   assign pol_o = pol_q;

endmodule

// File: rtl/nor_tree_pipe.sv
// Pipelined N-input NOR/OR reduction with valid/stall pipeline and saturating result counter.
module nor_tree_pipe
   import nor_tree_pkg::*;
#(
   parameter int unsigned N     = 9,
   parameter int unsigned RADIX = 3,
   parameter int unsigned CW    = 8
) (
   input  logic          ck,
   input  logic          nrst,
   input  logic          en,
   input  logic          vi,
   input  logic [N-1:0]  i,
   input  logic          pol,
   input  logic          clr,
   output logic          vo,
   output logic          nq,
   output logic [CW-1:0] cnt
);

   localparam int unsigned   LEVELS = clog_radix(N, RADIX);
   localparam logic [CW-1:0] CntMax = {CW{1'b1}};

   if (N < 2 || N > MaxN || RADIX < 2 || RADIX > 4 || CW < 1 || CW > 16) begin : g_param_check
      $fatal(1, "nor_tree_pipe: illegal parameters N=%0d RADIX=%0d CW=%0d", N, RADIX, CW);
   end

   // Index 0 is the raw input; index k is the output of register level k.
   logic [MaxN-1:0] lvl_data [LEVELS];
   logic            lvl_v    [LEVELS];
   logic            lvl_pol  [LEVELS];

   assign lvl_data[0] = MaxN'(i);
   assign lvl_v[0]    = vi;
   assign lvl_pol[0]  = pol;

   for (genvar k = 1; k < LEVELS; k++) begin : g_level
      localparam int unsigned WIN  = level_width(N, RADIX, k - 1);
      localparam int unsigned WOUT = level_width(N, RADIX, k);

      logic [WOUT-1:0] lvl_q;

      nor_tree_level #(
         .WIN   (WIN),
         .RADIX (RADIX)
      ) u_level (
         .clk_i  (ck),
         .rst_ni (nrst),
         .en_i   (en),
         .v_i    (lvl_v[k-1]),
         .pol_i  (lvl_pol[k-1]),
         .d_i    (lvl_data[k-1][WIN-1:0]),
         .v_o    (lvl_v[k]),
         .pol_o  (lvl_pol[k]),
         .d_o    (lvl_q)
      );

      assign lvl_data[k] = MaxN'(lvl_q);
   end

   logic          v_last, pol_last, res;
   logic          vo_d, vo_q, nq_d, nq_q;
   logic [CW-1:0] cnt_d, cnt_q;

   // Bits above the last level's width are tied to zero, so a full-width OR is exact.
   assign v_last   = lvl_v[LEVELS-1];
   assign pol_last = lvl_pol[LEVELS-1];
   assign res      = (|lvl_data[LEVELS-1]) ^ ~pol_last;

   always_comb begin
      vo_d  = vo_q;
      nq_d  = nq_q;
      cnt_d = cnt_q;
      if (en) begin
         vo_d = v_last;
         if (v_last) begin
            nq_d = res;
         end
      end
      if (clr) begin
         cnt_d = '0;
      end else if (en && v_last && res && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         vo_q  <= 1'b0;
         nq_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         vo_q  <= vo_d;
         nq_q  <= nq_d;
         cnt_q <= cnt_d;
      end
   end

   assign vo  = vo_q;
   assign nq  = nq_q;
   assign cnt = cnt_q;

endmodule

// File: tb/tb_nor_tree_pipe.sv
// Directed bench: N=9/7/2 trees, CW=2 saturation, stall and asynchronous reset sequences.
`timescale 1ns/1ps
module tb_nor_tree_pipe;

   logic       ck = 1'b0;
   logic       nrst, en, vi, pol, clr;
   logic [8:0] i9;
   logic [6:0] i7;
   logic [1:0] i2;

   logic       vo9, nq9, vo7, nq7, vo2, nq2, voc, nqc;
   logic [7:0] cnt9, cnt7, cnt2;
   logic [1:0] cntc;

   int checks = 0;
   int errors = 0;

   always #5 ck = ~ck;

   nor_tree_pipe #(.N(9), .RADIX(3), .CW(8)) dut9 (
      .ck(ck), .nrst(nrst), .en(en), .vi(vi), .i(i9), .pol(pol), .clr(clr),
      .vo(vo9), .nq(nq9), .cnt(cnt9)
   );
   nor_tree_pipe #(.N(7), .RADIX(3), .CW(8)) dut7 (
      .ck(ck), .nrst(nrst), .en(en), .vi(vi), .i(i7), .pol(pol), .clr(clr),
      .vo(vo7), .nq(nq7), .cnt(cnt7)
   );
   nor_tree_pipe #(.N(2), .RADIX(2), .CW(8)) dut2 (
      .ck(ck), .nrst(nrst), .en(en), .vi(vi), .i(i2), .pol(pol), .clr(clr),
      .vo(vo2), .nq(nq2), .cnt(cnt2)
   );
   nor_tree_pipe #(.N(9), .RADIX(3), .CW(2)) dutc (
      .ck(ck), .nrst(nrst), .en(en), .vi(vi), .i(i9), .pol(pol), .clr(clr),
      .vo(voc), .nq(nqc), .cnt(cntc)
   );

   typedef struct {
      logic [8:0] i9;
      logic [6:0] i7;
      logic [1:0] i2;
      logic       pol;
      logic       nq9;
      logic [7:0] cnt9;
      logic       nq7;
      logic       nq2;
   } vec_t;

   vec_t tbl [10];

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      tbl[0] = '{9'h000, 7'h00, 2'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1};
      tbl[1] = '{9'h100, 7'h40, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0};
      tbl[2] = '{9'h001, 7'h01, 2'd2, 1'b1, 1'b1, 8'd2, 1'b1, 1'b1};
      tbl[3] = '{9'h000, 7'h00, 2'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0};
      tbl[4] = '{9'h1FF, 7'h7F, 2'd3, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0};
      tbl[5] = '{9'h1FF, 7'h40, 2'd3, 1'b1, 1'b1, 8'd3, 1'b1, 1'b1};
      tbl[6] = '{9'h010, 7'h08, 2'd1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0};
      tbl[7] = '{9'h040, 7'h40, 2'd2, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1};
      tbl[8] = '{9'h080, 7'h20, 2'd0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0};
      tbl[9] = '{9'h020, 7'h00, 2'd2, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0};

      // Reset and idle
      nrst = 1'b0; en = 1'b1; vi = 1'b1; pol = 1'b0; clr = 1'b0;
      i9 = 9'h1FF; i7 = 7'h7F; i2 = 2'd3;
      repeat (3) tick();
      chk("rst_vo", vo9, 1'b0);
      chk("rst_nq", nq9, 1'b0);
      chk("rst_cnt", cnt9, 8'd0);
      #1;
      nrst = 1'b1;
      vi   = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("idle_vo", vo9, 1'b0);
         chk("idle_nq", nq9, 1'b0);
         chk("idle_cnt", cnt9, 8'd0);
      end

      // Single samples through all three tree shapes
      for (int n = 0; n < 10; n++) begin
         vi = 1'b1; i9 = tbl[n].i9; i7 = tbl[n].i7; i2 = tbl[n].i2; pol = tbl[n].pol;
         tick();
         chk("n2_vo_lat1", vo2, 1'b1);
         chk("n2_nq", nq2, tbl[n].nq2);
         chk("n9_vo_early", vo9, 1'b0);
         vi = 1'b0;
         tick();
         chk("n9_vo", vo9, 1'b1);
         chk("n9_nq", nq9, tbl[n].nq9);
         chk("n9_cnt", cnt9, tbl[n].cnt9);
         chk("n7_vo", vo7, 1'b1);
         chk("n7_nq", nq7, tbl[n].nq7);
         chk("n2_vo_drop", vo2, 1'b0);
         tick();
         chk("n9_vo_pulse", vo9, 1'b0);
         chk("n9_nq_hold", nq9, tbl[n].nq9);
      end

      // Back-to-back samples with different polarity
      vi = 1'b1; i9 = 9'h000; pol = 1'b0;
      tick();
      pol = 1'b1;
      tick();
      chk("pol_a_vo", vo9, 1'b1);
      chk("pol_a_nq", nq9, 1'b1);
      vi = 1'b0;
      tick();
      chk("pol_b_vo", vo9, 1'b1);
      chk("pol_b_nq", nq9, 1'b0);
      tick();
      chk("pol_end_vo", vo9, 1'b0);

      // Stall with two samples in flight
      clr = 1'b1; pol = 1'b0;
      tick();
      clr = 1'b0;
      chk("clr_cnt", cnt9, 8'd0);
      vi = 1'b1; i9 = 9'h1FF;
      tick();
      vi = 1'b0;
      repeat (2) tick();
      chk("prime_nq", nq9, 1'b0);
      vi = 1'b1; i9 = 9'h000;
      tick();
      i9 = 9'h001; en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall1_vo", vo9, 1'b0);
         chk("stall1_nq", nq9, 1'b0);
      end
      en = 1'b1;
      tick();
      chk("stall_a_vo", vo9, 1'b1);
      chk("stall_a_nq", nq9, 1'b1);
      chk("stall_a_cnt", cnt9, 8'd1);
      vi = 1'b0; en = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("stall2_vo", vo9, 1'b1);
         chk("stall2_nq", nq9, 1'b1);
         chk("stall2_cnt", cnt9, 8'd1);
      end
      en = 1'b1;
      tick();
      chk("stall_b_vo", vo9, 1'b1);
      chk("stall_b_nq", nq9, 1'b0);
      chk("stall_b_cnt", cnt9, 8'd1);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("stall_nodup_vo", vo9, 1'b0);
      end

      // Counter saturation at CW=2, then clear against a simultaneous increment
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("sat_clr", cntc, 2'd0);
      vi = 1'b1; i9 = 9'h000; pol = 1'b0;
      tick();
      chk("sat_c0", cntc, 2'd0);
      tick();
      chk("sat_c1", cntc, 2'd1);
      tick();
      chk("sat_c2", cntc, 2'd2);
      tick();
      chk("sat_c3", cntc, 2'd3);
      tick();
      chk("sat_c4", cntc, 2'd3);
      vi = 1'b0;
      tick();
      chk("sat_c5", cntc, 2'd3);
      chk("sat_n9_cnt", cnt9, 8'd5);
      vi = 1'b1;
      tick();
      vi = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_pri_vo", voc, 1'b1);
      chk("clr_pri_c", cntc, 2'd0);
      chk("clr_pri_9", cnt9, 8'd0);
      tick();

      // Asynchronous reset with samples in flight
      vi = 1'b1; i9 = 9'h000; pol = 1'b0;
      tick();
      tick();
      chk("mid_pre_vo", vo9, 1'b1);
      chk("mid_pre_cnt", cnt9, 8'd1);
      #1;
      nrst = 1'b0;
      #1;
      chk("mid_rst_vo", vo9, 1'b0);
      chk("mid_rst_nq", nq9, 1'b0);
      chk("mid_rst_cnt", cnt9, 8'd0);
      chk("mid_rst_cntc", cntc, 2'd0);
      vi = 1'b0;
      #1;
      nrst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("mid_post_vo", vo9, 1'b0);
         chk("mid_post_nq", nq9, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
